key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEB_CNT, default 4: consecutive stable cycles required to accept a key transition, legal range 2..255.
REQ-002 The block SHALL have parameter REP_DLY, default 50: held cycles before the first auto-repeat pulse (used only under KEY_REPEAT_EN).
REQ-003 The block SHALL have parameter REP_PER, default 10: cycles between subsequent auto-repeat pulses (used only under KEY_REPEAT_EN).
REQ-004 The block SHALL have port ck, input, 1: the single clock, rising edge.
REQ-005 The block SHALL have port clr, input, 1: the reset, synchronous and active-high.
REQ-006 The block SHALL have port KEY1, input, 1: raw push-button, active-low, asynchronous to ck.
REQ-007 The block SHALL have port KEY2, input, 1: raw push-button, active-low, asynchronous to ck.
REQ-008 The block SHALL have port SW, input, 8: raw slide switches SW9..SW2 on bits 7..0, asynchronous to ck.
REQ-009 The block SHALL have port key1_press, output, 1: single-cycle pulse on an accepted KEY1 press.
REQ-010 The block SHALL have port key2_press, output, 1: single-cycle pulse on an accepted KEY2 press.
REQ-011 The block SHALL have port key1_held, output, 1: debounced KEY1 level, 1 = pressed.
REQ-012 The block SHALL have port key2_held, output, 1: debounced KEY2 level, 1 = pressed.
REQ-013 The block SHALL have port sw_sync, output, 8: the SW bus passed through a 2-flop synchronizer.
REQ-014 The block SHALL have port sw_chg, output, 1: single-cycle pulse when any sw_sync bit changes.

Function
REQ-015 Each KEY SHALL pass through a 2-flop synchronizer before any other logic; SW SHALL pass through its own 2-flop synchronizer.
REQ-016 Each key SHALL run an independent FSM with states IDLE, DEB_DN, PRESSED and DEB_UP, each with its own 8-bit counter.
REQ-017 IDLE -> DEB_DN SHALL occur when the synchronized key is low; the counter SHALL load 1.
REQ-018 In DEB_DN, a synchronized high SHALL return the FSM to IDLE with counter 0; otherwise the counter SHALL increment.
REQ-019 DEB_DN -> PRESSED SHALL occur when the counter reaches DEB_CNT; key_press SHALL be 1 for exactly that one transition cycle.
REQ-020 Press latency SHALL be DEB_CNT+2 rising edges, counted from the first edge that samples the raw key low until key_press is high.
REQ-021 PRESSED -> DEB_UP SHALL occur on a synchronized high; DEB_UP SHALL mirror DEB_DN with the polarity inverted.
REQ-022 A synchronized low during DEB_UP SHALL return the FSM to PRESSED; reaching DEB_CNT SHALL go to IDLE with no pulse.
REQ-023 key_held SHALL be 1 in PRESSED and DEB_UP and 0 in IDLE and DEB_DN.
REQ-024 The two key FSMs SHALL be fully independent; simultaneous presses SHALL produce coincident pulses when their timing is equal.
REQ-025 sw_chg SHALL be 1 in the cycle after sw_sync differs from its own previous registered value; sw_chg latency from the raw SW change SHALL be 3 edges.
REQ-026 A bounce shorter than DEB_CNT cycles SHALL never produce key_press and SHALL never toggle key_held.

Reset
REQ-027 While clr=1 at an edge, the key synchronizer flops SHALL load 1 and all other flops SHALL load 0.
REQ-028 While clr=1, both FSMs SHALL enter IDLE, all counters SHALL clear, and every output SHALL be 0.
REQ-029 A reset asserted mid-debounce or while PRESSED SHALL discard that press; no pulse SHALL be emitted in the reset cycle or on release.
REQ-030 After reset release, switches already high SHALL produce exactly one sw_chg pulse when they reach sw_sync.

Configuration
REQ-031 With macro KEY_REPEAT_EN defined, a key held in PRESSED for REP_DLY cycles SHALL pulse key_press again, then every REP_PER cycles until it leaves PRESSED.
REQ-032 Auto-repeat SHALL be suppressed in DEB_UP, and any return to PRESSED SHALL restart the REP_DLY count.
REQ-033 Without KEY_REPEAT_EN, key_press SHALL pulse exactly once per accepted press, REP_DLY and REP_PER SHALL be unused, and no repeat counter SHALL be synthesized.

Verification
REQ-034 Directed test: DEB_CNT=4, KEY1 driven low at edge 10 and held -> key1_press=1 only at edge 16, and key1_held=1 from edge 16.
REQ-035 Directed test: KEY1 low for 3 cycles, high for 2, then low and held -> exactly one key1_press, at edge 6 after the final low.
REQ-036 Directed test: KEY1 and KEY2 driven low at the same edge -> key1_press and key2_press high in the same cycle.
REQ-037 Directed test: clr=1 for one cycle while KEY2 is PRESSED -> all outputs 0; the key2 FSM re-debounces and pulses DEB_CNT+2 edges after clr falls if the key is still held.
REQ-038 Directed test: SW changed from 8'h00 to 8'h81 at edge 5 -> sw_sync=8'h81 at edge 7 and sw_chg=1 at edge 8 only.
REQ-039 Directed test, KEY_REPEAT_EN with REP_DLY=50 and REP_PER=10: KEY1 held 100 cycles after acceptance -> pulses at +0, +50, +60, +70, +80, +90 and +100.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces two active-low push-buttons and
// synchronizes an 8-bit slide-switch bus with a change-detect pulse.
//
// Ports:
//   ck          clock, rising edge
//   clr         synchronous active-high reset
//   KEY1, KEY2  raw active-low push-buttons (asynchronous)
//   SW[7:0]     raw slide switches SW9..SW2 (asynchronous)
//   key1_press  one-cycle pulse on an accepted KEY1 press (plus repeats)
//   key2_press  one-cycle pulse on an accepted KEY2 press (plus repeats)
//   key1_held   debounced KEY1 level, 1 = pressed
//   key2_held   debounced KEY2 level, 1 = pressed
//   sw_sync     SW after a 2-flop synchronizer
//   sw_chg      one-cycle pulse after any sw_sync bit changes
//
// Build option: define KEY_REPEAT_EN to enable auto-repeat of key_press while
// a key stays pressed (first repeat after REP_DLY cycles, then every REP_PER).
module key_conditioner #(
  parameter int unsigned DEB_CNT = 4,
  parameter int unsigned REP_DLY = 50,
  parameter int unsigned REP_PER = 10
) (
  input  logic       ck,
  input  logic       clr,
  input  logic       KEY1,
  input  logic       KEY2,
  input  logic [7:0] SW,
  output logic       key1_press,
  output logic       key2_press,
  output logic       key1_held,
  output logic       key2_held,
  output logic [7:0] sw_sync,
  output logic       sw_chg
);

  localparam int unsigned NKEY  = 2;
  localparam int unsigned SW_W  = 8;
  localparam int unsigned CNT_W = 8;
  // Counter value at which the next stable sample completes DEB_CNT samples
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

  // Elaboration-time parameter range check
  if (DEB_CNT < 2 || DEB_CNT > 255 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_param
    $error("key_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEB_DN  = 2'd1,
    ST_PRESSED = 2'd2,
    ST_DEB_UP  = 2'd3
  } state_e;

  // Key synchronizers idle high so reset never looks like a press
  logic [NKEY-1:0] r_key_meta;
  logic [NKEY-1:0] r_key_sync;

  always_ff @(posedge ck) begin
    if (clr) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
    end else begin
      r_key_meta <= {KEY2, KEY1};
      r_key_sync <= r_key_meta;
    end
  end

  logic [NKEY-1:0] w_press;
  logic [NKEY-1:0] w_held;

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_press;
    logic             r_held;
    logic             w_press_d;
    logic             w_held_d;
    logic             w_rep_fire;

    // State register with registered outputs
    always_ff @(posedge ck) begin
      if (clr) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_press <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_press <= w_press_d;
        r_held  <= w_held_d;
      end
    end

    // Next-state: DEB_UP mirrors DEB_DN with inverted polarity
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_IDLE: begin
          if (!r_key_sync[g]) begin
            w_state_nxt = ST_DEB_DN;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_DEB_DN: begin
          if (r_key_sync[g]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (r_key_sync[g]) begin
            w_state_nxt = ST_DEB_UP;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        ST_DEB_UP: begin
          if (!r_key_sync[g]) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int unsigned REP_W   = $clog2(REP_MAX) + 1;

    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;

    // Down-counter to the next repeat; reloaded on every entry into PRESSED
    always_comb begin
      w_rep_nxt  = r_rep;
      w_rep_fire = 1'b0;
      if (w_state_nxt == ST_PRESSED) begin
        if (r_state != ST_PRESSED) begin
          w_rep_nxt = REP_W'(REP_DLY - 1);
        end else if (r_rep == '0) begin
          w_rep_fire = 1'b1;
          w_rep_nxt  = REP_W'(REP_PER - 1);
        end else begin
          w_rep_nxt  = r_rep - REP_W'(1);
        end
      end
    end

    always_ff @(posedge ck) begin
      if (clr) begin
        r_rep <= '0;
      end else begin
        r_rep <= w_rep_nxt;
      end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Outputs: press on DEB_DN -> PRESSED (or repeat), held in PRESSED/DEB_UP
    always_comb begin
      w_press_d = 1'b0;
      w_held_d  = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_DEB_UP);
      if ((r_state == ST_DEB_DN) && (w_state_nxt == ST_PRESSED)) begin
        w_press_d = 1'b1;
      end
      if (w_rep_fire) begin
        w_press_d = 1'b1;
      end
    end

    assign w_press[g] = r_press;
    assign w_held[g]  = r_held;
  end

  // Switch synchronizer and change detector
  logic [SW_W-1:0] r_sw_meta;
  logic [SW_W-1:0] r_sw_sync;
  logic [SW_W-1:0] r_sw_prev;
  logic            r_sw_chg;

  always_ff @(posedge ck) begin
    if (clr) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_sw_prev <= '0;
      r_sw_chg  <= 1'b0;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
      r_sw_prev <= r_sw_sync;
      r_sw_chg  <= (r_sw_sync != r_sw_prev);
    end
  end

  assign key1_press = w_press[0];
  assign key2_press = w_press[1];
  assign key1_held  = w_held[0];
  assign key2_held  = w_held[1];
  assign sw_sync    = r_sw_sync;
  assign sw_chg     = r_sw_chg;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: hand-written vector table, directed corner
// sequences and randomized stimulus against a run-length debounce model.
module tb_key_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 50;
  localparam int unsigned RP  = 10;

  logic       ck = 1'b0;
  logic       clr;
  logic       KEY1;
  logic       KEY2;
  logic [7:0] SW;
  logic       key1_press;
  logic       key2_press;
  logic       key1_held;
  logic       key2_held;
  logic [7:0] sw_sync;
  logic       sw_chg;

  key_conditioner #(.DEB_CNT(DEB), .REP_DLY(RD), .REP_PER(RP)) dut (
    .ck        (ck),
    .clr       (clr),
    .KEY1      (KEY1),
    .KEY2      (KEY2),
    .SW        (SW),
    .key1_press(key1_press),
    .key2_press(key2_press),
    .key1_held (key1_held),
    .key2_held (key2_held),
    .sw_sync   (sw_sync),
    .sw_chg    (sw_chg)
  );

  always #5 ck = ~ck;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: raw sample history, debounced level and run length of
  // samples disagreeing with that level, time spent stably pressed.
  logic       kh    [2][2];
  logic       m_lvl [2];
  int         m_run [2];
  int         m_hold[2];
  logic       m_press[2];
  logic [7:0] sh[4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic raw[2];
    logic s;
    logic want;
    raw[0] = KEY1;
    raw[1] = KEY2;
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        kh[k][0] = 1'b1; kh[k][1] = 1'b1;
        m_lvl[k] = 1'b0; m_run[k] = 0; m_hold[k] = 0; m_press[k] = 1'b0;
      end
      for (int j = 0; j < 4; j++) sh[j] = 8'h00;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      s        = kh[k][1];
      kh[k][1] = kh[k][0];
      kh[k][0] = raw[k];
      want     = ~s;
      m_press[k] = 1'b0;
      if (want != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == int'(DEB)) begin
          m_lvl[k] = want;
          m_run[k] = 0;
          if (want) begin
            m_press[k] = 1'b1;
            m_hold[k]  = 0;
          end
        end
      end else begin
        if (m_lvl[k]) begin
          if (m_run[k] > 0) begin
            m_hold[k] = 0;
          end else begin
            m_hold[k]++;
`ifdef KEY_REPEAT_EN
            if (m_hold[k] >= int'(RD) && ((m_hold[k] - int'(RD)) % int'(RP)) == 0)
              m_press[k] = 1'b1;
`endif
          end
        end
        m_run[k] = 0;
      end
    end
    sh[3] = sh[2]; sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = SW;
  endtask

  // One clock: update model at the edge, compare all outputs 1 ns later
  task automatic tick();
    @(posedge ck);
    cyc++;
    model_edge();
    #1;
    chk("key1_press", 8'(key1_press), 8'(m_press[0]));
    chk("key2_press", 8'(key2_press), 8'(m_press[1]));
    chk("key1_held",  8'(key1_held),  8'(m_lvl[0]));
    chk("key2_held",  8'(key2_held),  8'(m_lvl[1]));
    chk("sw_sync",    sw_sync,        sh[1]);
    chk("sw_chg",     8'(sw_chg),     8'(sh[2] != sh[3]));
  endtask

  // Run n clocks, counting press pulses and the first offset of each
  task automatic window(input int n, output int c1, output int f1,
                        output int c2, output int f2);
    c1 = 0; f1 = -1; c2 = 0; f2 = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (key1_press) begin c1++; if (f1 < 0) f1 = i; end
      if (key2_press) begin c2++; if (f2 < 0) f2 = i; end
    end
  endtask

  typedef struct {
    logic       clr;
    logic       k1;
    logic       k2;
    logic [7:0] sw;
    logic       e_held;
    logic [7:0] e_sync;
    logic       e_chg;
  } vec_t;

  vec_t vt[14];

  initial begin
    int c1, f1, c2, f2, nchg;
    int rep_got[$];
    int rep_exp[$];
    int rate;

    clr = 1'b1; KEY1 = 1'b1; KEY2 = 1'b1; SW = 8'h00;

    // Reset, then SW 00 -> 81 -> 3C -> 00 with keys idle
    vt[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 8'h81, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h81, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b1};
    vt[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[13] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

    for (int i = 0; i < 14; i++) begin
      clr = vt[i].clr; KEY1 = vt[i].k1; KEY2 = vt[i].k2; SW = vt[i].sw;
      tick();
      chk("tbl_press1", 8'(key1_press), 8'h00);
      chk("tbl_press2", 8'(key2_press), 8'h00);
      chk("tbl_held1",  8'(key1_held),  8'(vt[i].e_held));
      chk("tbl_held2",  8'(key2_held),  8'(vt[i].e_held));
      chk("tbl_sw_sync", sw_sync,       vt[i].e_sync);
      chk("tbl_sw_chg", 8'(sw_chg),     8'(vt[i].e_chg));
    end

    // Press latency: pulse exactly 6 edges after the drive, held from then on
    KEY1 = 1'b0;
    window(5, c1, f1, c2, f2);
    chk("lat_early_press", 8'(c1), 8'd0);
    chk("lat_early_held", 8'(key1_held), 8'd0);
    window(1, c1, f1, c2, f2);
    chk("lat_press", 8'(c1), 8'd1);
    chk("lat_held", 8'(key1_held), 8'd1);
    window(6, c1, f1, c2, f2);
    chk("lat_single", 8'(c1), 8'd0);
    KEY1 = 1'b1;
    window(12, c1, f1, c2, f2);
    chk("release_nopulse", 8'(c1), 8'd0);
    chk("release_held", 8'(key1_held), 8'd0);

    // Bounce: 3 low, 2 high, then low and held
    KEY1 = 1'b0;
    window(3, c1, f1, c2, f2);
    chk("bounce_p1", 8'(c1), 8'd0);
    KEY1 = 1'b1;
    window(2, c1, f1, c2, f2);
    chk("bounce_p2", 8'(c1), 8'd0);
    chk("bounce_held", 8'(key1_held), 8'd0);
    KEY1 = 1'b0;
    window(10, c1, f1, c2, f2);
    chk("bounce_count", 8'(c1), 8'd1);
    chk("bounce_offset", 8'(f1), 8'd6);
    KEY1 = 1'b1;
    window(12, c1, f1, c2, f2);

    // Simultaneous presses
    KEY1 = 1'b0; KEY2 = 1'b0;
    window(10, c1, f1, c2, f2);
    chk("simul_cnt1", 8'(c1), 8'd1);
    chk("simul_cnt2", 8'(c2), 8'd1);
    chk("simul_off1", 8'(f1), 8'd6);
    chk("simul_off2", 8'(f2), 8'd6);
    KEY1 = 1'b1; KEY2 = 1'b1;
    window(12, c1, f1, c2, f2);

    // Reset while KEY2 pressed, key still held afterwards
    KEY2 = 1'b0;
    window(10, c1, f1, c2, f2);
    chk("pre_clr_held2", 8'(key2_held), 8'd1);
    clr = 1'b1;
    tick();
    chk("clr_press2", 8'(key2_press), 8'd0);
    chk("clr_held2",  8'(key2_held),  8'd0);
    chk("clr_held1",  8'(key1_held),  8'd0);
    chk("clr_sw_chg", 8'(sw_chg),     8'd0);
    clr = 1'b0;
    window(12, c1, f1, c2, f2);
    chk("post_clr_cnt", 8'(c2), 8'd1);
    chk("post_clr_off", 8'(f2), 8'd6);
    KEY2 = 1'b1;
    window(12, c1, f1, c2, f2);
    chk("post_clr_release", 8'(c2), 8'd0);

    // Long hold: repeat pulses only when auto-repeat is built in
    KEY1 = 1'b0;
    window(6, c1, f1, c2, f2);
    chk("hold_accept", 8'(f1), 8'd6);
`ifdef KEY_REPEAT_EN
    rep_exp = '{50, 60, 70, 80, 90, 100};
`endif
    for (int j = 1; j <= 105; j++) begin
      tick();
      if (key1_press) rep_got.push_back(j);
    end
    chk("hold_pulses", 8'(rep_got.size()), 8'(rep_exp.size()));
    for (int j = 0; j < rep_exp.size() && j < rep_got.size(); j++)
      chk("hold_offset", 8'(rep_got[j]), 8'(rep_exp[j]));
    KEY1 = 1'b1;
    window(12, c1, f1, c2, f2);

    // Switches high through reset give exactly one change pulse
    SW = 8'hFF; clr = 1'b1;
    tick();
    clr = 1'b0;
    nchg = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (sw_chg) nchg++;
    end
    chk("sw_after_reset", 8'(nchg), 8'd1);

    // Randomized phases with alternating bounce rates
    rate = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rate = (rate == 3) ? 40 : 3;
      if ($urandom_range(0, rate) == 0) KEY1 = ~KEY1;
      if ($urandom_range(0, rate) == 0) KEY2 = ~KEY2;
      if ($urandom_range(0, 15) == 0) SW = 8'($urandom);
      clr = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
